// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam int unsigned STALL_W_DEFAULT  = 6;

  // REQ: address on the bus; WAIT: address accepted, data pending; HOLD: word buffered
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_next_pc.sv
// Next-PC priority mux: redirect, then taken branch, then sequential pc+4.
module if_fetch_next_pc (
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc_c
);

  logic [31:0] seq_pc;

  // Sequential address wraps modulo 2^32
  assign seq_pc = 32'(pc + 32'd4);

  // A flush this cycle is newer than any pending redirect, so it wins
  always_comb begin
    next_pc_c = seq_pc;
    if (flush) begin
      next_pc_c = new_pc;
    end else if (redir_valid) begin
      next_pc_c = redir_pc;
    end else if (branch_flag) begin
      next_pc_c = branch_target;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction bus, feeds IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned STALL_W  = STALL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic               branch_flag,
  input  logic [31:0]        branch_target,
  output logic               inst_req,
  output logic [31:0]        inst_addr,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok,
  input  logic [31:0]        inst_rdata,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               if_adel,
  output logic               stallreq_if
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  redir_pc;
  logic [31:0]  buffer;
  logic [31:0]  next_pc;
  logic         redir_valid;
  logic         cancel;
  logic         misaligned;
  logic         data_hit;
  logic         avail;
  logic         valid;
  logic         unused_stall;

  // Only stall[0] governs the PC; the upper bits belong to later stages
  assign unused_stall = &{1'b0, stall[STALL_W-1:1]};

  assign misaligned = (pc[1:0] != 2'b00);
  assign data_hit   = (state == ST_WAIT) && inst_data_ok && !cancel;
  assign avail      = data_hit || (state == ST_HOLD) || misaligned;
  // A redirect in progress suppresses whatever would otherwise be presented
  assign valid      = avail && !flush && !redir_valid && !reset;

  assign inst_req    = !reset && (state == ST_REQ) && !misaligned;
  assign inst_addr   = pc;
  assign if_pc       = pc;
  assign if_adel     = misaligned;
  assign stallreq_if = !valid && !reset;

  // Instruction word to IF/ID: live bus data, buffered word, or NOP
  always_comb begin
    if_inst = NOP;
    if (valid && !misaligned) begin
      if_inst = data_hit ? inst_rdata : buffer;
    end
  end

  if_fetch_next_pc u_next_pc (
    .pc            (pc),
    .flush         (flush),
    .new_pc        (new_pc),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .next_pc_c     (next_pc)
  );

  // Fetch FSM, PC register, redirect capture and instruction buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      redir_valid <= 1'b0;
      redir_pc    <= 32'h0;
      cancel      <= 1'b0;
      buffer      <= NOP;
    end else begin
      if (flush) begin
        redir_valid <= 1'b1;
        redir_pc    <= new_pc;
      end
      case (state)
        ST_REQ: begin
          if (misaligned) begin
            // Nothing on the bus, so a redirect can take effect at once
            if (flush || !stall[0]) begin
              pc          <= next_pc;
              redir_valid <= 1'b0;
            end
          end else if (inst_addr_ok) begin
            state  <= ST_WAIT;
            cancel <= flush || redir_valid;
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            if (cancel || flush) begin
              cancel      <= 1'b0;
              state       <= ST_REQ;
              pc          <= next_pc;
              redir_valid <= 1'b0;
            end else if (!stall[0]) begin
              state <= ST_REQ;
              pc    <= next_pc;
            end else begin
              buffer <= inst_rdata;
              state  <= ST_HOLD;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (flush || !stall[0]) begin
            state       <= ST_REQ;
            pc          <= next_pc;
            redir_valid <= 1'b0;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a hand-driven instruction bus.
module tb_if_fetch;

  logic        clk;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        stallreq_if;

  int total;
  int bad;

  if_fetch #(
    .RESET_PC (32'hBFC0_0000),
    .STALL_W  (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_adel       (if_adel),
    .stallreq_if   (stallreq_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    stall = 6'h00;
    flush = 1'b0;
    new_pc = 32'h0;
    branch_flag = 1'b0;
    branch_target = 32'h0;
    bus(1'b0, 1'b0, 32'h0);

    // reset held across an edge
    nxt();
    chk("rst_req", 32'(inst_req), 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", if_pc, 32'hBFC0_0000);
    chk("rst_stallreq", 32'(stallreq_if), 32'h0);

    // cycle 0: first request, no addr_ok yet
    reset = 1'b0;
    #1;
    chk("c0_req", 32'(inst_req), 32'h1);
    chk("c0_addr", inst_addr, 32'hBFC0_0000);
    chk("c0_stallreq", 32'(stallreq_if), 32'h1);
    // cycle 1: address accepted
    nxt(); bus(1'b1, 1'b0, 32'h0); #1;
    chk("c1_addr", inst_addr, 32'hBFC0_0000);
    chk("c1_stallreq", 32'(stallreq_if), 32'h1);
    // cycle 2: waiting
    nxt(); bus(1'b0, 1'b0, 32'h0); #1;
    chk("c2_req", 32'(inst_req), 32'h0);
    chk("c2_stallreq", 32'(stallreq_if), 32'h1);
    // cycle 3: data returns
    nxt(); bus(1'b0, 1'b1, 32'h2408_0001); #1;
    chk("c3_inst", if_inst, 32'h2408_0001);
    chk("c3_stallreq", 32'(stallreq_if), 32'h0);
    // cycle 4: sequential request
    nxt(); bus(1'b1, 1'b0, 32'h0); #1;
    chk("c4_addr", inst_addr, 32'hBFC0_0004);
    chk("c4_req", 32'(inst_req), 32'h1);
    chk("c4_inst", if_inst, 32'h0);

    // stall[0] for three cycles starting at data_ok -> HOLD
    nxt(); bus(1'b0, 1'b1, 32'h8C09_0010); stall = 6'h01; #1;
    chk("s5_inst", if_inst, 32'h8C09_0010);
    chk("s5_stallreq", 32'(stallreq_if), 32'h0);
    nxt(); bus(1'b0, 1'b0, 32'hDEAD_BEEF); #1;
    chk("s6_inst_held", if_inst, 32'h8C09_0010);
    chk("s6_req", 32'(inst_req), 32'h0);
    nxt(); #1;
    chk("s7_inst_held", if_inst, 32'h8C09_0010);
    chk("s7_stallreq", 32'(stallreq_if), 32'h0);
    nxt(); stall = 6'h00; #1;
    chk("s8_inst_release", if_inst, 32'h8C09_0010);
    nxt(); bus(1'b1, 1'b0, 32'h0); #1;
    chk("s9_addr", inst_addr, 32'hBFC0_0008);
    chk("s9_req", 32'(inst_req), 32'h1);

    // taken branch at the advance cycle
    nxt(); bus(1'b0, 1'b1, 32'h1000_0004); branch_flag = 1'b1; branch_target = 32'hBFC0_0100; #1;
    chk("b10_inst", if_inst, 32'h1000_0004);
    nxt(); bus(1'b1, 1'b0, 32'h0); branch_flag = 1'b0; #1;
    chk("b11_addr", inst_addr, 32'hBFC0_0100);

    // flush while WAIT: returned word discarded
    nxt(); bus(1'b0, 1'b0, 32'h0); flush = 1'b1; new_pc = 32'hBFC0_0380; #1;
    chk("fw12_inst", if_inst, 32'h0);
    chk("fw12_stallreq", 32'(stallreq_if), 32'h1);
    nxt(); bus(1'b0, 1'b1, 32'h3C1D_0000); flush = 1'b0; #1;
    chk("fw13_inst_dropped", if_inst, 32'h0);
    chk("fw13_stallreq", 32'(stallreq_if), 32'h1);
    nxt(); bus(1'b1, 1'b0, 32'h0); #1;
    chk("fw14_addr", inst_addr, 32'hBFC0_0380);
    chk("fw14_req", 32'(inst_req), 32'h1);
    nxt(); bus(1'b0, 1'b1, 32'h2408_0380); #1;
    chk("fw15_inst", if_inst, 32'h2408_0380);

    // flush during REQ with addr_ok withheld two cycles
    nxt(); bus(1'b0, 1'b0, 32'h0); flush = 1'b1; new_pc = 32'hBFC0_0380; #1;
    chk("fr16_addr", inst_addr, 32'hBFC0_0384);
    chk("fr16_req", 32'(inst_req), 32'h1);
    nxt(); flush = 1'b0; #1;
    chk("fr17_addr_stable", inst_addr, 32'hBFC0_0384);
    chk("fr17_stallreq", 32'(stallreq_if), 32'h1);
    nxt(); bus(1'b1, 1'b0, 32'h0); #1;
    chk("fr18_addr_stable", inst_addr, 32'hBFC0_0384);
    nxt(); bus(1'b0, 1'b1, 32'h2408_0384); #1;
    chk("fr19_inst_dropped", if_inst, 32'h0);
    chk("fr19_stallreq", 32'(stallreq_if), 32'h1);
    nxt(); bus(1'b1, 1'b0, 32'h0); #1;
    chk("fr20_addr", inst_addr, 32'hBFC0_0380);

    // branch to a misaligned target, then recover by flush
    nxt(); bus(1'b0, 1'b1, 32'h2408_0380); branch_flag = 1'b1; branch_target = 32'hBFC0_0102; #1;
    chk("m21_inst", if_inst, 32'h2408_0380);
    nxt(); bus(1'b0, 1'b0, 32'h0); branch_flag = 1'b0; stall = 6'h01; #1;
    chk("m22_adel", 32'(if_adel), 32'h1);
    chk("m22_inst", if_inst, 32'h0);
    chk("m22_req", 32'(inst_req), 32'h0);
    chk("m22_pc", if_pc, 32'hBFC0_0102);
    chk("m22_stallreq", 32'(stallreq_if), 32'h0);
    nxt(); flush = 1'b1; new_pc = 32'hBFC0_0380; #1;
    chk("m23_inst", if_inst, 32'h0);
    chk("m23_stallreq", 32'(stallreq_if), 32'h1);
    nxt(); flush = 1'b0; stall = 6'h00; bus(1'b1, 1'b0, 32'h0); #1;
    chk("m24_addr", inst_addr, 32'hBFC0_0380);
    chk("m24_req", 32'(inst_req), 32'h1);
    chk("m24_adel", 32'(if_adel), 32'h0);

    // pc+4 wrap from the top of the address space
    nxt(); bus(1'b0, 1'b1, 32'h0000_0001); branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC; #1;
    nxt(); bus(1'b1, 1'b0, 32'h0); branch_flag = 1'b0; #1;
    chk("w26_addr", inst_addr, 32'hFFFF_FFFC);
    nxt(); bus(1'b0, 1'b1, 32'h2408_FFFF); #1;
    chk("w27_inst", if_inst, 32'h2408_FFFF);
    nxt(); bus(1'b1, 1'b0, 32'h0); #1;
    chk("w28_addr_wrap", inst_addr, 32'h0000_0000);

    // reset mid-transaction; a stray data_ok afterwards is ignored
    nxt(); bus(1'b0, 1'b0, 32'h0); reset = 1'b1; #1;
    chk("r29_req", 32'(inst_req), 32'h0);
    nxt(); reset = 1'b0; bus(1'b0, 1'b1, 32'h1234_5678); #1;
    chk("r30_inst", if_inst, 32'h0);
    chk("r30_addr", inst_addr, 32'hBFC0_0000);
    chk("r30_stallreq", 32'(stallreq_if), 32'h1);
    nxt(); bus(1'b0, 1'b0, 32'h0); #1;
    chk("r31_req", 32'(inst_req), 32'h1);
    chk("r31_addr", inst_addr, 32'hBFC0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
